// File: rtl/vend_pkg.sv
// Shared constants and state types for the vending machine datapath and sequencer.
package vend_pkg;

   localparam logic [3:0] P15 = 4'b0001;
   localparam logic [3:0] P20 = 4'b0010;
   localparam logic [3:0] P25 = 4'b0100;
   localparam logic [3:0] P30 = 4'b1000;

   localparam logic [7:0] E0  = 8'h00;
   localparam logic [7:0] E5  = 8'h05;
   localparam logic [7:0] E10 = 8'h10;
   localparam logic [7:0] E15 = 8'h15;
   localparam logic [7:0] E20 = 8'h20;
   localparam logic [7:0] E25 = 8'h25;
   localparam logic [7:0] E30 = 8'h30;
   localparam logic [7:0] E35 = 8'h35;

   typedef enum logic [2:0] {
      StIdle, StMotor, StDimeHi, StDimeLo, StNickHi, StNickLo, StDone, StFault
   } vend_state_e;

   typedef enum logic [1:0] {HsIdle, HsHi, HsLo} hs_state_e;

   function automatic logic vend_legal(logic [3:0] item, logic [7:0] change);
      return (item inside {P15, P20, P25, P30}) && (change[7:4] <= 4'd9) &&
             (change[3:0] == 4'd0 || change[3:0] == 4'd5);
   endfunction

endpackage

// File: rtl/hopper_handshake.sv
// One 4-phase req/ack channel to a coin hopper, with a per-phase ack timeout.
module hopper_handshake
   import vend_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 1000,
   parameter int unsigned CNT_W       = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic ack,
   output logic req,
   output logic ack_seen,
   output logic done,
   output logic timeout
);

   hs_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;

   assign ack_seen = (state_q == HsHi) && ack;
   assign done     = (state_q == HsLo) && !ack;
   // An ack arriving on the last allowed cycle still wins over the timeout.
   assign timeout  = ((state_q == HsHi && !ack) || (state_q == HsLo && ack)) &&
                     (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HsIdle;
         req     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            HsIdle: begin
               if (start) begin
                  state_q <= HsHi;
                  req     <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            HsHi: begin
               if (ack) begin
                  state_q <= HsLo;
                  req     <= 1'b0;
                  cnt_q   <= '0;
               end else if (timeout) begin
                  state_q <= HsIdle;
                  req     <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HsLo: begin
               if (!ack) begin
                  state_q <= start ? HsHi : HsIdle;
                  req     <= start;
                  cnt_q   <= '0;
               end else if (timeout) begin
                  state_q <= HsIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= HsIdle;
               req     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Runs the item motor, then pays change (dimes first, then at most one nickel) via
// two hopper handshakes; latches a sticky fault if a hopper stops responding.
module vend_dispense_sequencer
   import vend_pkg::*;
#(
   parameter int unsigned MOTOR_CYCLES = 50,
   parameter int unsigned ACK_TIMEOUT  = 1000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vend_start,
   input  logic [3:0] item_sel,
   input  logic [7:0] change_bcd,
   output logic       busy,
   output logic [3:0] motor_en,
   output logic       dime_req,
   input  logic       dime_ack,
   output logic       nickel_req,
   input  logic       nickel_ack,
   output logic [7:0] change_left_bcd,
   output logic       vend_done,
   output logic       bad_req,
   output logic       fault
);

   vend_state_e      state_q;
   vend_state_e      pay_next;
   logic [CNT_W-1:0] cnt_q;
   logic             motor_last, pay_step, dime_start, nick_start;
   logic             dime_ack_seen, dime_done, dime_timeout;
   logic             nick_ack_seen, nick_done, nick_timeout;

   assign busy       = (state_q != StIdle);
   assign motor_last = (cnt_q == CNT_W'(MOTOR_CYCLES - 1));
   assign pay_step   = (state_q == StMotor && motor_last) || (state_q == StDimeLo && dime_done);
   assign dime_start = pay_step && (pay_next == StDimeHi);
   assign nick_start = pay_step && (pay_next == StNickHi);

   always_comb begin
      pay_next = StDone;
      if (change_left_bcd[7:4] != 4'd0) begin
         pay_next = StDimeHi;
      end else if (change_left_bcd[3:0] == 4'd5) begin
         pay_next = StNickHi;
      end
   end

   hopper_handshake #(
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_dime (
      .clk     (clk),
      .reset   (reset),
      .start   (dime_start),
      .ack     (dime_ack),
      .req     (dime_req),
      .ack_seen(dime_ack_seen),
      .done    (dime_done),
      .timeout (dime_timeout)
   );

   hopper_handshake #(
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_nickel (
      .clk     (clk),
      .reset   (reset),
      .start   (nick_start),
      .ack     (nickel_ack),
      .req     (nickel_req),
      .ack_seen(nick_ack_seen),
      .done    (nick_done),
      .timeout (nick_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         motor_en        <= '0;
         change_left_bcd <= E0;
         vend_done       <= 1'b0;
         bad_req         <= 1'b0;
         fault           <= 1'b0;
      end else begin
         vend_done <= 1'b0;
         bad_req   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (vend_start) begin
                  if (vend_legal(item_sel, change_bcd)) begin
                     state_q         <= StMotor;
                     motor_en        <= item_sel;
                     change_left_bcd <= change_bcd;
                     cnt_q           <= '0;
                  end else begin
                     bad_req <= 1'b1;
                  end
               end
            end
            StMotor: begin
               if (motor_last) begin
                  motor_en  <= '0;
                  state_q   <= pay_next;
                  vend_done <= (pay_next == StDone);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDimeHi: begin
               if (dime_ack_seen) begin
                  change_left_bcd <= change_left_bcd - E10;
                  state_q         <= StDimeLo;
               end else if (dime_timeout) begin
                  state_q <= StFault;
                  fault   <= 1'b1;
               end
            end
            StDimeLo: begin
               if (dime_done) begin
                  state_q   <= pay_next;
                  vend_done <= (pay_next == StDone);
               end else if (dime_timeout) begin
                  state_q <= StFault;
                  fault   <= 1'b1;
               end
            end
            StNickHi: begin
               if (nick_ack_seen) begin
                  change_left_bcd[3:0] <= 4'd0;
                  state_q              <= StNickLo;
               end else if (nick_timeout) begin
                  state_q <= StFault;
                  fault   <= 1'b1;
               end
            end
            StNickLo: begin
               if (nick_done) begin
                  state_q   <= StDone;
                  vend_done <= 1'b1;
               end else if (nick_timeout) begin
                  state_q <= StFault;
                  fault   <= 1'b1;
               end
            end
            StDone: begin
               change_left_bcd <= E0;
               state_q         <= StIdle;
            end
            default: state_q <= StFault;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Randomized bench for the dispense sequencer: hopper models with random ack delays and a
// transaction-level reference of how each sale must play out.
module tb_vend_dispense_sequencer;
   import vend_pkg::*;

   localparam int unsigned MC = 50;
   localparam int unsigned TO = 64;

   logic       clk = 1'b0;
   logic       reset, vend_start;
   logic [3:0] item_sel;
   logic [7:0] change_bcd;
   logic       busy, dime_req, dime_ack, nickel_req, nickel_ack;
   logic       vend_done, bad_req, fault;
   logic [3:0] motor_en;
   logic [7:0] change_left_bcd;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int dime_hs = 0, nick_hs = 0, done_cnt = 0, bad_cnt = 0, motor_cyc = 0, motor_bad = 0;
   int viol = 0, overlap = 0, motor_first = 0, done_cyc = 0, dime_rise_cyc = 0, fault_cyc = 0;
   logic [7:0] trace[$];
   logic [3:0] cur_item = '0;
   bit         dime_stuck = 1'b0;
   logic       p_dreq = 1'b0, p_nreq = 1'b0, p_fault = 1'b0;
   logic [3:0] p_motor = '0;
   logic [7:0] p_chg = '0;

   vend_dispense_sequencer #(
      .MOTOR_CYCLES(MC),
      .ACK_TIMEOUT (TO),
      .CNT_W       (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .vend_start     (vend_start),
      .item_sel       (item_sel),
      .change_bcd     (change_bcd),
      .busy           (busy),
      .motor_en       (motor_en),
      .dime_req       (dime_req),
      .dime_ack       (dime_ack),
      .nickel_req     (nickel_req),
      .nickel_ack     (nickel_ack),
      .change_left_bcd(change_left_bcd),
      .vend_done      (vend_done),
      .bad_req        (bad_req),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] to_bcd(int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic bit ref_legal(logic [3:0] it, logic [7:0] ch);
      return ($countones(it) == 1) && (ch[7:4] < 4'd10) && (ch[3:0] == 4'd0 || ch[3:0] == 4'd5);
   endfunction

   function automatic logic [17:0] all_outs();
      return {busy, motor_en, dime_req, nickel_req, change_left_bcd, vend_done, bad_req, fault};
   endfunction

   // Hopper models: ack after a random delay, release a random delay after req drops.
   initial begin
      dime_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (dime_req && !dime_stuck) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dime_ack = 1'b1;
            for (int i = 0; i < 4000 && dime_req; i++) @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dime_ack = 1'b0;
         end
      end
   end

   initial begin
      nickel_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (nickel_req) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            nickel_ack = 1'b1;
            for (int i = 0; i < 4000 && nickel_req; i++) @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            nickel_ack = 1'b0;
         end
      end
   end

   // Observer: acks only change on negedges, so values here equal those seen at the edge.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (!reset) begin
         if (dime_req && !p_dreq) begin
            dime_hs++;
            dime_rise_cyc = cyc;
            if (dime_ack) viol++;
         end
         if (!dime_req && p_dreq && !dime_ack && !fault) viol++;
         if (nickel_req && !p_nreq) begin
            nick_hs++;
            if (nickel_ack) viol++;
         end
         if (!nickel_req && p_nreq && !nickel_ack && !fault) viol++;
         if (dime_req && nickel_req) overlap++;
         if (motor_en != 4'd0) begin
            motor_cyc++;
            if (motor_en != cur_item) motor_bad++;
            if (p_motor == 4'd0) motor_first = cyc;
         end
         if (vend_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bad_req) bad_cnt++;
         if (change_left_bcd != p_chg) trace.push_back(change_left_bcd);
         if (fault && !p_fault) fault_cyc = cyc;
      end
      p_dreq  = dime_req;
      p_nreq  = nickel_req;
      p_motor = motor_en;
      p_chg   = change_left_bcd;
      p_fault = fault;
   end

   task automatic run_vend(input logic [3:0] it, input logic [7:0] ch);
      int b_d = dime_hs, b_n = nick_hs, b_done = done_cnt, b_bad = bad_cnt;
      int b_mc = motor_cyc, b_mb = motor_bad, b_v = viol, b_o = overlap;
      int b_t = trace.size();
      int start_m, budget, c;
      logic [7:0] exp_t[$];
      cur_item = it;
      @(negedge clk);
      vend_start = 1'b1;
      item_sel   = it;
      change_bcd = ch;
      start_m    = cyc;
      @(negedge clk);
      vend_start = 1'b0;
      budget = 0;
      // Stray starts while busy, legal or not, must be ignored.
      while (done_cnt == b_done && budget < 3000) begin
         @(negedge clk);
         budget++;
         if (done_cnt == b_done && busy && $urandom_range(0, 7) == 0) begin
            vend_start = 1'b1;
            item_sel   = 4'($urandom);
            change_bcd = 8'($urandom);
         end else begin
            vend_start = 1'b0;
         end
      end
      vend_start = 1'b0;
      repeat (3) @(negedge clk);
      c = int'(ch[7:4]) * 10 + int'(ch[3:0]);
      if (c != 0) begin
         exp_t.push_back(to_bcd(c));
         while (c >= 10) begin
            c -= 10;
            exp_t.push_back(to_bcd(c));
         end
         if (c == 5) exp_t.push_back(to_bcd(0));
      end
      check("done_pulses", done_cnt - b_done, 1);
      check("dime_handshakes", dime_hs - b_d, 32'(ch[7:4]));
      check("nickel_handshakes", nick_hs - b_n, 32'(ch[3:0] == 4'd5));
      check("motor_cycles", motor_cyc - b_mc, MC);
      check("motor_value", motor_bad - b_mb, 0);
      check("motor_start_cycle", motor_first, start_m + 1);
      if (ch == E0) check("done_latency", done_cyc - motor_first, MC);
      check("handshake_rules", viol - b_v, 0);
      check("req_overlap", overlap - b_o, 0);
      check("bad_req_while_busy", bad_cnt - b_bad, 0);
      check("trace_len", trace.size() - b_t, exp_t.size());
      for (int i = 0; i < exp_t.size() && b_t + i < trace.size(); i++)
         check("change_trace", 32'(trace[b_t + i]), 32'(exp_t[i]));
      check("idle_after_vend", 32'(all_outs()), 0);
   endtask

   task automatic bad_start(input logic [3:0] it, input logic [7:0] ch);
      int b = bad_cnt, bm = motor_cyc;
      @(negedge clk);
      vend_start = 1'b1;
      item_sel   = it;
      change_bcd = ch;
      @(negedge clk);
      vend_start = 1'b0;
      repeat (3) @(negedge clk);
      check("bad_req_pulses", bad_cnt - b, 1);
      check("bad_no_motor", motor_cyc - bm, 0);
      check("bad_stays_idle", {31'd0, busy}, 0);
   endtask

   task automatic apply(input logic [3:0] it, input logic [7:0] ch);
      if (ref_legal(it, ch)) run_vend(it, ch);
      else bad_start(it, ch);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b, budget;
      logic [3:0] it;
      logic [7:0] ch;
      reset      = 1'b1;
      vend_start = 1'b0;
      item_sel   = '0;
      change_bcd = '0;
      repeat (3) @(negedge clk);
      check("reset_state", 32'(all_outs()), 0);
      reset = 1'b0;

      apply(P15, E20);
      apply(P20, E15);
      apply(P30, E0);
      apply(4'b0011, E20);
      apply(P15, 8'h07);
      apply(P15, 8'hA0);

      // Dime hopper never answers: sticky fault with unpaid change shown.
      dime_stuck = 1'b1;
      cur_item   = P20;
      @(negedge clk);
      vend_start = 1'b1;
      item_sel   = P20;
      change_bcd = E10;
      @(negedge clk);
      vend_start = 1'b0;
      budget = 0;
      while (!fault && budget < int'(MC + TO + 100)) begin
         @(negedge clk);
         budget++;
      end
      check("fault_raised", {31'd0, fault}, 1);
      check("fault_latency", fault_cyc - dime_rise_cyc, TO);
      check("fault_outputs", {18'd0, dime_req, nickel_req, motor_en, change_left_bcd},
            {18'd0, 2'b00, 4'd0, E10});
      @(negedge clk);
      vend_start = 1'b1;
      item_sel   = P15;
      change_bcd = E0;
      @(negedge clk);
      vend_start = 1'b0;
      repeat (20) @(negedge clk);
      check("fault_sticky", {22'd0, fault, busy, change_left_bcd}, {22'd0, 2'b11, E10});
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      dime_stuck = 1'b0;
      check("reset_after_fault", 32'(all_outs()), 0);

      // Reset during the second dime handshake, then a clean vend.
      cur_item = P15;
      b = dime_hs;
      @(negedge clk);
      vend_start = 1'b1;
      item_sel   = P15;
      change_bcd = E20;
      @(negedge clk);
      vend_start = 1'b0;
      budget = 0;
      while (dime_hs - b < 2 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      check("second_dime_seen", dime_hs - b, 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_mid_vend", 32'(all_outs()), 0);
      repeat (2) @(negedge clk);
      apply(P25, E35);

      for (int n = 0; n < 20; n++) begin
         it = ($urandom_range(0, 3) != 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
         if ($urandom_range(0, 9) < 7) ch = {4'($urandom_range(0, 9)), ($urandom_range(0, 1) != 0) ? 4'd5 : 4'd0};
         else ch = 8'($urandom);
         apply(it, ch);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vend_dispense_sequencer.md
Name: vend_dispense_sequencer

Overview:
Sequences the physical completion of a sale for the vending machine. When the credit/price FSM finalises a vend, it issues `vend_start` with the selected item and the change owed (BCD cents). This block then:
- runs the item motor for a fixed time;
- pays change through the dime and nickel hoppers using a 4-phase req/ack handshake;
- reports done, or latches a fault if a hopper stops responding.

Parameters:
MOTOR_CYCLES, 50, clock cycles `motor_en` is held for one vend (≥1)
ACK_TIMEOUT, 1000, max cycles waiting on any ack edge before FAULT (≥2)
CNT_W, 16, width of the shared motor/timeout counter; must hold max(MOTOR_CYCLES, ACK_TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vend_start  in  1  one-cycle request to dispense; sampled only in IDLE
item_sel  in  4  one-hot item (0001=15c, 0010=20c, 0100=25c, 1000=30c)
change_bcd  in  8  change owed, 2-digit BCD cents; legal: tens 0-9, ones 0 or 5
busy  out  1  high in every state except IDLE
motor_en  out  4  one-hot motor drive (latched item_sel) during MOTOR
dime_req  out  1  dime hopper request
dime_ack  in  1  dime hopper acknowledge
nickel_req  out  1  nickel hopper request
nickel_ack  in  1  nickel hopper acknowledge
change_left_bcd  out  8  BCD change still to pay; feeds left display
vend_done  out  1  one-cycle pulse, sale completed
bad_req  out  1  one-cycle pulse, vend_start rejected as illegal
fault  out  1  sticky hopper-timeout flag; cleared only by reset

Behaviour:
- Reset (sync): state IDLE; all outputs 0; `change_left_bcd`=8'h00; counter 0; latched item 0.
- States: IDLE, MOTOR, DIME_HI, DIME_LO, NICK_HI, NICK_LO, DONE, FAULT.
- IDLE:
  - `vend_start`=1 with legal inputs → latch `item_sel` and `change_bcd` (`change_left_bcd` updates next edge), go to MOTOR, counter=0.
  - Illegal inputs → `bad_req`=1 for the next cycle, stay in IDLE. Illegal means: `item_sel` not exactly one-hot, tens>9, or ones∉{0,5}.
  - `vend_start` in any other state is ignored (no queueing).
- MOTOR:
  - `motor_en`=latched item for exactly MOTOR_CYCLES cycles, then 0.
  - Next state, in priority order: DIME_HI if tens≠0; else NICK_HI if ones=5; else DONE.
- DIME_HI:
  - `dime_req`=1.
  - On `dime_ack`=1 → tens decrements by 1 (`change_left_bcd` −8'h10), go to DIME_LO.
- DIME_LO:
  - `dime_req`=0.
  - On `dime_ack`=0 → DIME_HI if tens≠0; else NICK_HI if ones=5; else DONE.
- NICK_HI / NICK_LO: same handshake on the nickel pair. The ack in NICK_HI clears the ones digit to 0. NICK_LO exits to DONE.
- Pay order: all dimes first, then at most one nickel.
- Handshake rules:
  - A req never drops before its ack is seen high.
  - A new req never rises while the previous ack is still high.
  - At most one req is high at any time.
- Timeout:
  - The counter restarts on entry to each *_HI/*_LO state.
  - If the awaited ack edge has not arrived after ACK_TIMEOUT cycles → FAULT.
  - FAULT: `fault`=1, `busy`=1, all reqs and `motor_en`=0, `change_left_bcd` frozen (shows unpaid change). Leave only by reset.
- DONE: `vend_done`=1 for one cycle, `change_left_bcd`=8'h00, then IDLE.
- Ack for the idle hopper (e.g. `nickel_ack` during dime phase): ignored.
- An ack already high on entry to *_HI counts immediately (1-cycle handshake phase).
- Reset mid-sequence: immediate return to reset values; remaining change is discarded.
- Latency with zero change: `vend_start` at edge N → `motor_en` high N+1..N+MOTOR_CYCLES → `vend_done` at N+MOTOR_CYCLES+1.

Decomposition:
- Shared package `vend_pkg`:
  - price/item one-hot constants (P15..P30);
  - BCD amount constants (E0..E35);
  - state enum for this block.
- One sub-module, `hopper_handshake`: one req/ack 4-phase channel with timeout (start, ack → req, done, timeout). Instantiated twice (dime, nickel); both instances share the same CNT_W/ACK_TIMEOUT.

Test Plan:
1. Reset, `item_sel`=0001, `change_bcd`=8'h20, pulse `vend_start`, hopper model acks after 3 cycles → exactly 2 `dime_req` handshakes, 0 nickel handshakes; `change_left_bcd` goes 20→10→00; one `vend_done` pulse; `busy` then 0.
2. `item_sel`=0010, `change_bcd`=8'h15 → 1 dime then 1 nickel; `change_left_bcd` goes 15→05→00; `dime_req` and `nickel_req` never overlap.
3. `item_sel`=1000, `change_bcd`=8'h00, MOTOR_CYCLES=50 → `motor_en`=1000 for exactly 50 cycles; `vend_done` on the cycle after; no hopper reqs.
4. Illegal starts (`item_sel`=0011; `change_bcd`=8'h07; `change_bcd`=8'hA0) → `bad_req` pulses once each; state stays IDLE; `busy`=0.
5. `change_bcd`=8'h10, `dime_ack` held 0 → after ACK_TIMEOUT cycles `fault`=1, `dime_req`=0, `change_left_bcd`=8'h10; stays until reset; reset clears all outputs.
6. Assert reset during the second dime handshake of an 8'h20 vend → next cycle all outputs 0 and IDLE. A fresh `vend_start` then completes normally, and `vend_start` pulses issued while `busy`=1 are ignored.
